// File: rtl/burst_mem_pkg.sv
// Shared types and sizes for the burst memory responder.
// Holds the FSM state enum, beat geometry and beat-index type.
package burst_mem_pkg;

  localparam int BEATS      = 4;
  localparam int BEAT_W     = 64;
  localparam int LINE_OFS_W = 5;
  localparam int LINE_W     = BEATS * BEAT_W;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    BURST,
    DONE
  } state_t;

  typedef logic [1:0] beat_t;

endpackage

// File: rtl/burst_mem_array.sv
// Line store: LINES x 256 bits, registered full-line read port,
// 64-bit beat-granular write port. Contents are never reset.
module burst_mem_array
  import burst_mem_pkg::*;
#(
  parameter int LINES = 256,
  localparam int IDX_W = $clog2(LINES)
) (
  input  logic              clk,
  input  logic [IDX_W-1:0]  raddr,
  output logic [LINE_W-1:0] rline,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  beat_t             wbeat,
  input  logic [BEAT_W-1:0] wdata
);

  logic [LINE_W-1:0] mem [LINES];

  always_ff @(posedge clk) begin
    if (we)
      mem[waddr][int'(wbeat)*BEAT_W +: BEAT_W] <= wdata;
    rline <= mem[raddr];
  end

endmodule

// File: rtl/burst_mem_responder.sv
// Burst memory responder: 4-beat read/write bursts after LATENCY cycles.
// Ports: clk, rst (async low), pmem_* bus, err. Macro: BURST_MEM_RESPONDER_ERR_EN.
module burst_mem_responder
  import burst_mem_pkg::*;
#(
  parameter int LINES   = 256,
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pmem_address,
  input  logic        pmem_read,
  input  logic        pmem_write,
  input  logic [63:0] pmem_wdata,
  output logic [63:0] pmem_rdata,
  output logic        pmem_resp,
  output logic        err
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TOP_L = LINE_OFS_W + IDX_W;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  beat_t             beat_q, beat_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              rd_q, rd_d;
  logic              req;
  logic [IDX_W-1:0]  idx_in;
  logic [IDX_W-1:0]  raddr;
  logic [LINE_W-1:0] rline;
  logic [63:0]       rdata_d;
  logic              resp_d;
  logic              we;

  assign req    = pmem_read | pmem_write;
  assign idx_in = pmem_address[LINE_OFS_W +: IDX_W];

  // In IDLE the incoming index is read so the line is ready
  // before the first beat, even with a single WAIT cycle.
  assign raddr = (state_q == IDLE) ? idx_in : idx_q;
  assign we    = (state_q == BURST) && !rd_q;

  burst_mem_array #(
    .LINES (LINES)
  ) u_array (
    .clk   (clk),
    .raddr (raddr),
    .rline (rline),
    .we    (we),
    .waddr (idx_q),
    .wbeat (beat_q),
    .wdata (pmem_wdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    idx_d   = idx_q;
    rd_d    = rd_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          state_d = WAIT;
          cnt_d   = 4'(LATENCY - 1);
          idx_d   = idx_in;
          rd_d    = pmem_read;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = BURST;
          beat_d  = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      BURST: begin
        beat_d = beat_q + 2'd1;
        if (beat_q == 2'd3)
          state_d = DONE;
      end
      DONE: state_d = IDLE;
    endcase
  end

  // Outputs registered from next state so they align with BURST.
  always_comb begin
    resp_d  = (state_d == BURST);
    rdata_d = '0;
    if (resp_d && rd_d)
      rdata_d = rline[int'(beat_d)*BEAT_W +: BEAT_W];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      beat_q     <= '0;
      idx_q      <= '0;
      rd_q       <= 1'b0;
      pmem_resp  <= 1'b0;
      pmem_rdata <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      beat_q     <= beat_d;
      idx_q      <= idx_d;
      rd_q       <= rd_d;
      pmem_resp  <= resp_d;
      pmem_rdata <= rdata_d;
    end
  end

`ifdef BURST_MEM_RESPONDER_ERR_EN
  logic [31:LINE_OFS_W] addr_q;
  logic                 busy;
  logic                 own_req;
  logic                 err_set;
  logic                 unused_addr;

  assign unused_addr = ^pmem_address[LINE_OFS_W-1:0];
  assign busy    = (state_q == WAIT) || (state_q == BURST);
  assign own_req = rd_q ? pmem_read : pmem_write;

  always_comb begin
    err_set = pmem_read && pmem_write;
    if (busy) begin
      if (!own_req)
        err_set = 1'b1;
      if (pmem_address[31:LINE_OFS_W] != addr_q)
        err_set = 1'b1;
      if ((pmem_read != rd_q) || (pmem_write == rd_q))
        err_set = 1'b1;
    end
    if ((state_q == IDLE) && req &&
        (pmem_address[31:TOP_L] != '0))
      err_set = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q <= '0;
      err    <= 1'b0;
    end else begin
      if ((state_q == IDLE) && req)
        addr_q <= pmem_address[31:LINE_OFS_W];
      if (err_set)
        err <= 1'b1;
    end
  end
`else
  logic unused_addr;

  assign unused_addr = ^{pmem_address[31:TOP_L],
                         pmem_address[LINE_OFS_W-1:0]};
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_burst_mem_responder.sv
// Self-checking bench for burst_mem_responder.
// Two instances: LATENCY=4 (main) and LATENCY=1 (back-to-back).
module tb_burst_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_req [2];
  logic        wr_req [2];
  logic [31:0] addr   [2];
  logic [63:0] wdata  [2];
  logic [63:0] rdata  [2];
  logic        resp   [2];
  logic        err    [2];

  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  int          first_cyc;
  int          last_cyc;
  logic        exp_err;
  bit          err_en;
  logic [63:0] ref_mem [512][4];
  logic [63:0] pat [4];
  int          written [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  burst_mem_responder #(
    .LINES   (256),
    .LATENCY (4)
  ) u_dut0 (
    .clk          (clk),
    .rst          (rst),
    .pmem_address (addr[0]),
    .pmem_read    (rd_req[0]),
    .pmem_write   (wr_req[0]),
    .pmem_wdata   (wdata[0]),
    .pmem_rdata   (rdata[0]),
    .pmem_resp    (resp[0]),
    .err          (err[0])
  );

  burst_mem_responder #(
    .LINES   (256),
    .LATENCY (1)
  ) u_dut1 (
    .clk          (clk),
    .rst          (rst),
    .pmem_address (addr[1]),
    .pmem_read    (rd_req[1]),
    .pmem_write   (wr_req[1]),
    .pmem_wdata   (wdata[1]),
    .pmem_rdata   (rdata[1]),
    .pmem_resp    (resp[1]),
    .err          (err[1])
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  function automatic int lat(input int sel);
    return (sel == 1) ? 1 : 4;
  endfunction

  // One burst as the initiator sees it.
  // extra: request already held through DONE.
  // hold: keep request asserted in DONE.
  // abort_beat: pull reset during that beat (-1 none).
  task automatic burst(input int sel,
                       input bit r,
                       input bit w,
                       input logic [31:0] a,
                       input bit fixed,
                       input int extra,
                       input bit hold,
                       input int abort_beat);
    int          base;
    bit          is_rd;
    logic [63:0] wd [4];
    base  = sel * 256 + int'((a >> 5) % 256);
    is_rd = r;
    for (int n = 0; n < 4; n++)
      wd[n] = fixed ? pat[n] : {$urandom, $urandom};
    if (extra == 0) begin
      @(posedge clk); #1;
      chk("idle_resp", 64'(resp[sel]), 64'd0);
    end
    rd_req[sel] = r;
    wr_req[sel] = w;
    addr[sel]   = a;
    wdata[sel]  = wd[0];
    repeat (lat(sel) + extra) begin
      @(posedge clk); #1;
      chk("lat_resp", 64'(resp[sel]), 64'd0);
    end
    for (int n = 0; n < 4; n++) begin
      @(posedge clk); #1;
      if (n == 0) first_cyc = cyc;
      if (n == 3) last_cyc = cyc;
      chk("beat_resp", 64'(resp[sel]), 64'd1);
      chk("beat_rdata", rdata[sel],
          is_rd ? ref_mem[base][n] : 64'd0);
      if (n == abort_beat) begin
        #1 rst = 1'b0;
        #1;
        chk("abort_resp", 64'(resp[sel]), 64'd0);
        chk("abort_rdata", rdata[sel], 64'd0);
        rd_req[sel] = 1'b0;
        wr_req[sel] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        return;
      end
      wdata[sel] = wd[n];
      if (!is_rd) ref_mem[base][n] = wd[n];
    end
    @(posedge clk); #1;
    chk("done_resp", 64'(resp[sel]), 64'd0);
    chk("done_rdata", rdata[sel], 64'd0);
    if (!hold) begin
      rd_req[sel] = 1'b0;
      wr_req[sel] = 1'b0;
    end
  endtask

  initial begin
    int          idx;
    int          prev_last;
    logic [31:0] a;
    err_en = 1'b0;
`ifdef BURST_MEM_RESPONDER_ERR_EN
    err_en = 1'b1;
`endif
    exp_err = 1'b0;
    for (int s = 0; s < 2; s++) begin
      rd_req[s] = 1'b0;
      wr_req[s] = 1'b0;
      addr[s]   = '0;
      wdata[s]  = '0;
    end

    #2 rst = 1'b0;
    #10;
    for (int s = 0; s < 2; s++) begin
      chk("rst_resp", 64'(resp[s]), 64'd0);
      chk("rst_rdata", rdata[s], 64'd0);
      chk("rst_err", 64'(err[s]), 64'd0);
    end
    @(negedge clk);
    rst = 1'b1;

    // Directed write then read of 0x40.
    pat[0] = {16{4'h1}};
    pat[1] = {16{4'h2}};
    pat[2] = {16{4'h3}};
    pat[3] = {16{4'h4}};
    burst(0, 0, 1, 32'h40, 1, 0, 0, -1);
    burst(0, 1, 0, 32'h40, 0, 0, 0, -1);

    // Random lines, random ignored offset bits.
    for (int i = 0; i < 6; i++) begin
      idx = $urandom_range(16, 63);
      a   = 32'(idx << 5) | 32'($urandom_range(0, 31));
      burst(0, 0, 1, a, 0, 0, 0, -1);
      written.push_back(idx);
      idx = written[$urandom_range(0, written.size() - 1)];
      a   = 32'(idx << 5) | 32'($urandom_range(0, 31));
      burst(0, 1, 0, a, 0, 0, 0, -1);
    end
    chk("err_clean", 64'(err[0]), 64'(exp_err));

    // Read and write together: read wins.
    burst(0, 0, 1, 32'h80, 0, 0, 0, -1);
    burst(0, 1, 1, 32'h80, 0, 0, 0, -1);
    if (err_en) exp_err = 1'b1;
    chk("err_rdwr", 64'(err[0]), 64'(exp_err));
    burst(0, 1, 0, 32'h80, 0, 0, 0, -1);

    // Request held through DONE.
    burst(0, 1, 0, 32'h40, 0, 0, 1, -1);
    burst(0, 1, 0, 32'h40, 0, 1, 0, -1);

    // Reset during beat 2 of a write.
    burst(0, 0, 1, 32'h100, 0, 0, 0, -1);
    burst(0, 0, 1, 32'h100, 0, 0, 0, 2);
    exp_err = 1'b0;
    chk("err_after_rst", 64'(err[0]), 64'(exp_err));
    burst(0, 1, 0, 32'h100, 0, 0, 0, -1);

    // Upper address bits wrap to line 2.
    burst(0, 1, 0, 32'h2040, 0, 0, 0, -1);
    if (err_en) exp_err = 1'b1;
    chk("err_wrap", 64'(err[0]), 64'(exp_err));

    // LATENCY=1 back-to-back reads.
    burst(1, 0, 1, 32'h0, 0, 0, 0, -1);
    burst(1, 0, 1, 32'h20, 0, 0, 0, -1);
    burst(1, 1, 0, 32'h0, 0, 0, 0, -1);
    prev_last = last_cyc;
    burst(1, 1, 0, 32'h20, 0, 0, 0, -1);
    chk("b2b_gap", 64'(first_cyc - prev_last - 1), 64'd3);
    chk("err_dut1", 64'(err[1]), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/burst_mem_responder.md
BURST_MEM_RESPONDER -- requirements
Module: burst_mem_responder

Interface
REQ-001 SHALL have parameter LINES, default 256: number of 32-byte lines in the backing store (power of two).
REQ-002 SHALL have parameter LATENCY, default 4: idle cycles from request acceptance to first response beat (range 1-15).
REQ-003 SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port pmem_address  input  32: line address; bits [4:0] ignored, index = bits [5+log2(LINES)-1:5].
REQ-006 SHALL have port pmem_read  input  1: read burst request, held high until the final beat.
REQ-007 SHALL have port pmem_write  input  1: write burst request, held high until the final beat.
REQ-008 SHALL have port pmem_wdata  input  64: write beat; the initiator advances it after each pmem_resp cycle.
REQ-009 SHALL have port pmem_rdata  output  64: read beat, valid only while pmem_resp is high.
REQ-010 SHALL have port pmem_resp  output  1: beat strobe; high for exactly 4 consecutive cycles per burst.
REQ-011 SHALL have port err  output  1: sticky protocol-error flag (see Configuration).

Function
REQ-012 SHALL implement FSM states IDLE, WAIT, BURST and DONE.
REQ-013 IDLE: SHALL accept on pmem_read|pmem_write, latch address and direction, load the latency counter with LATENCY-1, and go to WAIT.
REQ-014 Simultaneous read and write in IDLE: SHALL serve the read (read priority).
REQ-015 WAIT: SHALL decrement the counter and enter BURST with beat counter 0 when the counter reaches 0.
REQ-016 BURST: SHALL drive pmem_resp high and increment the 2-bit beat counter each cycle; on beat 3 it SHALL go to DONE.
REQ-017 Read beat n: pmem_rdata SHALL equal line[idx] bits [64n+63:64n] in the same cycle pmem_resp is high; both outputs are registered.
REQ-018 Write beat n: SHALL store pmem_wdata into line[idx] beat n on each BURST cycle.
REQ-019 DONE: SHALL hold pmem_resp low for one cycle and return to IDLE, ignoring a still-asserted request that cycle.
REQ-020 Latency: the first beat SHALL appear LATENCY+1 cycles after the request is sampled; the next request is accepted at the earliest 6+LATENCY cycles after the previous one.
REQ-021 A request dropped or changed mid-burst SHALL NOT abort the burst; it completes with the latched address and direction.
REQ-022 An address whose upper bits exceed LINES SHALL wrap modulo LINES.
REQ-023 pmem_rdata SHALL be 0 whenever pmem_resp is low.

Reset
REQ-024 With rst low, SHALL force the FSM to IDLE, pmem_resp=0, pmem_rdata=0, err=0 and both counters to 0, asynchronously.
REQ-025 Reset mid-burst SHALL abort the burst; write beats already stored SHALL remain; array contents SHALL never be reset.

Configuration
REQ-026 Macro BURST_MEM_RESPONDER_ERR_EN defined: err SHALL set on any of the following: read and write both high; request deasserted during WAIT or BURST; address or direction changed during WAIT or BURST; address bits [31:5+log2(LINES)] nonzero at acceptance. err SHALL clear only on reset.
REQ-027 Macro undefined: err SHALL be tied to 0 and no checking logic SHALL be built.

Structure
REQ-028 Package burst_mem_pkg SHALL hold the state enum, BEATS=4, BEAT_W=64, LINE_OFS_W=5 and the beat-index type.
REQ-029 Storage SHALL be the sub-module burst_mem_array: LINES x 256 bits, one synchronous read port and one 64-bit beat-granular write port.

Verification
REQ-030 Reset, write burst at 0x00000040 with beats 0x11..11, 0x22..22, 0x33..33, 0x44..44, then read 0x00000040: rdata SHALL return the same 4 beats in order, with resp high for exactly 4 cycles starting LATENCY+1 cycles after the request.
REQ-031 Read and write asserted together at 0x80: SHALL perform a read, leave the line unmodified, and (ERR_EN) set err=1.
REQ-032 Request held high through DONE: SHALL produce no 5th resp cycle, and SHALL start a new burst only on the next IDLE sample.
REQ-033 rst low at beat 2 of a write to 0x100: resp SHALL drop immediately; a subsequent read of 0x100 SHALL return new beats 0-1 and old beats 2-3.
REQ-034 LINES=256, read 0x00002040: (ERR_EN) SHALL set err=1 and return line index 2 data.
REQ-035 LATENCY=1 back-to-back reads at 0x0 and 0x20: the gap between resp bursts SHALL be exactly 3 cycles (1 DONE + 1 IDLE + 1 WAIT).
